// File: rtl/dtmr_pkg.sv
// Shared constants and helpers for the triplicated (DTMR) datapath blocks.
package dtmr_pkg;

  // Number of redundant domains.
  localparam int DTMR_N = 3;

  // Default per-domain counter width.
  localparam int DTMR_WIDTH_DEF = 4;

  // Identifies one redundant domain.
  typedef enum logic [1:0] {
    DOM_0 = 2'd0,
    DOM_1 = 2'd1,
    DOM_2 = 2'd2
  } dtmr_dom_e;

  // Single-bit 2-of-3 majority; wider votes apply it bit by bit.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage : dtmr_pkg

// File: rtl/dtmr_voter_w.sv
// WIDTH-bit bitwise 2-of-3 majority voter, one instance per domain.
module dtmr_voter_w
  import dtmr_pkg::*;
#(
  parameter int WIDTH = DTMR_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  output logic [WIDTH-1:0] o_v
);

  // Each output bit follows the majority of the three corresponding input bits.
  always_comb begin
    o_v = '0;
    for (int unsigned b = 0; b < WIDTH; b++) begin
      o_v[b] = maj3(i_a[b], i_b[b], i_c[b]);
    end
  end

endmodule : dtmr_voter_w

// File: rtl/dtmr_counter.sv
// Triplicated up-counter. Every domain re-votes all three raw registers with
// its own voter, so a single corrupted register is masked at the output and
// rewritten at the next edge; a per-domain sticky flag records disagreement.
module dtmr_counter
  import dtmr_pkg::*;
#(
  parameter int WIDTH = DTMR_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             port_en_0,
  input  logic             port_en_1,
  input  logic             port_en_2,
  input  logic             port_clr_0,
  input  logic             port_clr_1,
  input  logic             port_clr_2,
  output logic [WIDTH-1:0] port_cnt_0,
  output logic [WIDTH-1:0] port_cnt_1,
  output logic [WIDTH-1:0] port_cnt_2,
  output logic             port_tc_0,
  output logic             port_tc_1,
  output logic             port_tc_2,
  output logic             port_err_0,
  output logic             port_err_1,
  output logic             port_err_2
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  // Raw per-domain state.
  logic [WIDTH-1:0]  r_cnt [DTMR_N];
  logic [DTMR_N-1:0] r_err;

  // Per-domain combinational signals.
  logic [DTMR_N-1:0] w_en;
  logic [DTMR_N-1:0] w_clr;
  logic [WIDTH-1:0]  w_vote    [DTMR_N];
  logic [WIDTH-1:0]  w_cnt_nxt [DTMR_N];
  logic [DTMR_N-1:0] w_err_nxt;
  logic [DTMR_N-1:0] w_mm;
  logic [DTMR_N-1:0] w_tc;

  assign w_en  = {port_en_2, port_en_1, port_en_0};
  assign w_clr = {port_clr_2, port_clr_1, port_clr_0};

  // One voter and one mismatch detector per domain; nothing is shared.
  for (genvar d = 0; d < DTMR_N; d++) begin : g_dom
    dtmr_voter_w #(
      .WIDTH (WIDTH)
    ) u_voter (
      .i_a (r_cnt[0]),
      .i_b (r_cnt[1]),
      .i_c (r_cnt[2]),
      .o_v (w_vote[d])
    );

    assign w_mm[d] = (r_cnt[0] != r_cnt[1]) | (r_cnt[1] != r_cnt[2]);
    assign w_tc[d] = w_en[d] & (w_vote[d] == CNT_MAX);
  end

  // Next state: clear beats enable; otherwise count or rewrite with the vote.
  always_comb begin
    for (int unsigned d = 0; d < DTMR_N; d++) begin
      w_cnt_nxt[d] = w_vote[d];
      w_err_nxt[d] = r_err[d] | w_mm[d];
      if (w_clr[d]) begin
        w_cnt_nxt[d] = '0;
        w_err_nxt[d] = 1'b0;
      end else if (w_en[d]) begin
        w_cnt_nxt[d] = w_vote[d] + 1'b1;
      end
    end
  end

  // State registers for all three domains, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned d = 0; d < DTMR_N; d++) begin
        r_cnt[d] <= '0;
      end
      r_err <= '0;
    end else begin
      for (int unsigned d = 0; d < DTMR_N; d++) begin
        r_cnt[d] <= w_cnt_nxt[d];
      end
      r_err <= w_err_nxt;
    end
  end

  assign port_cnt_0 = w_vote[0];
  assign port_cnt_1 = w_vote[1];
  assign port_cnt_2 = w_vote[2];
  assign port_tc_0  = w_tc[0];
  assign port_tc_1  = w_tc[1];
  assign port_tc_2  = w_tc[2];
  assign port_err_0 = r_err[0];
  assign port_err_1 = r_err[1];
  assign port_err_2 = r_err[2];

endmodule : dtmr_counter
